flit_compare_checker: RTL

Parametrised streaming successor to the die-A loopback flit checker. It compares an expected flit stream against an actual return stream pair-wise, in order, as flits arrive, instead of waiting for end of traffic. It reports a sticky error, a saturating error count, the index of the first mismatching flit, FIFO overflow and a drain timeout. It sits in the full-example testbench/top between the LPIF traffic generator and the pass/fail monitor.

---
 rtl/lpif_chk_pkg.sv | 15 +
 rtl/chk_sync_fifo.sv | 66 ++++++
 rtl/flit_compare_checker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lpif_chk_pkg.sv
// Shared types for the streaming flit compare checker: FSM states and
// test_done encodings.
package lpif_chk_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } chk_state_e;

  localparam logic [1:0] TD_RUN  = 2'b00;
  localparam logic [1:0] TD_PASS = 2'b11;
  localparam logic [1:0] TD_FAIL = 2'b10;

endpackage

// File: rtl/chk_sync_fifo.sv
// Single-clock FIFO with registered read data; a push into a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module chk_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;
  assign rdata   = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage and read register carry data only, so they are not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
    if (do_pop)  rdata_q <= mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/flit_compare_checker.sv
// Streaming in-order comparison of expected vs. actual flit streams with
// sticky error reporting, overflow detection and drain timeout.
module flit_compare_checker
  import lpif_chk_pkg::*;
#(
  parameter int DATA_W     = 528,
  parameter int CMP_LO     = 128,
  parameter int CMP_HI     = 255,
  parameter int FIFO_DEPTH = 64,
  parameter int ERR_CNT_W  = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 wr_rd_done,
  input  logic                 exp_valid,
  input  logic [DATA_W-1:0]    exp_data,
  input  logic                 act_valid,
  input  logic [DATA_W-1:0]    act_data,
  output logic                 data_error,
  output logic [1:0]           test_done,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          flit_count,
  output logic [31:0]          first_err_idx,
  output logic                 fifo_overflow,
  output logic                 timeout
);

  localparam int CW = CMP_HI - CMP_LO + 1;
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] CMP_MASK =
    ((DATA_W'(1) << CW) - DATA_W'(1)) << CMP_LO;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  chk_state_e           state_q, state_d;
  logic                 cmp_vld_q, cmp_vld_d;
  logic                 first_seen_q, first_seen_d;
  logic                 data_error_q, data_error_d;
  logic [1:0]           test_done_q, test_done_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [31:0]          flit_count_q, flit_count_d;
  logic [31:0]          first_err_idx_q, first_err_idx_d;
  logic                 fifo_overflow_q, fifo_overflow_d;
  logic                 timeout_q, timeout_d;
  logic [SW-1:0]        stall_cnt_q, stall_cnt_d;

  logic          exp_full, exp_empty, act_full, act_empty;
  logic [CW-1:0] exp_rd, act_rd;
  logic          pop, exp_push, act_push, exp_ovf, act_ovf, stalled;
  logic          unused_bits;

  // Bits outside the compare field never reach the FIFOs.
  assign unused_bits = ^((exp_data ^ act_data) & ~CMP_MASK);

  assign pop      = !exp_empty && !act_empty && (state_q != DONE) && !clear;
  assign exp_push = exp_valid && (!exp_full || pop) && !clear;
  assign act_push = act_valid && (!act_full || pop) && !clear;
  assign exp_ovf  = exp_valid && exp_full && !pop && !clear;
  assign act_ovf  = act_valid && act_full && !pop && !clear;
  assign stalled  = (exp_empty != act_empty) && !exp_push && !act_push;

  chk_sync_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_exp_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (clear),
    .push  (exp_push),
    .pop   (pop),
    .wdata (exp_data[CMP_HI:CMP_LO]),
    .rdata (exp_rd),
    .full  (exp_full),
    .empty (exp_empty)
  );

  chk_sync_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_act_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (clear),
    .push  (act_push),
    .pop   (pop),
    .wdata (act_data[CMP_HI:CMP_LO]),
    .rdata (act_rd),
    .full  (act_full),
    .empty (act_empty)
  );

  always_comb begin
    state_d         = state_q;
    cmp_vld_d       = pop;
    first_seen_d    = first_seen_q;
    data_error_d    = data_error_q;
    test_done_d     = test_done_q;
    err_count_d     = err_count_q;
    flit_count_d    = flit_count_q;
    first_err_idx_d = first_err_idx_q;
    fifo_overflow_d = fifo_overflow_q;
    timeout_d       = timeout_q;
    stall_cnt_d     = '0;

    // Compare stage: registered FIFO heads from last cycle's pop.
    if (cmp_vld_q) begin
      flit_count_d = flit_count_q + 32'd1;
      if (exp_rd != act_rd) begin
        err_count_d  = sat_inc(err_count_q);
        data_error_d = 1'b1;
        if (!first_seen_q) begin
          first_seen_d    = 1'b1;
          first_err_idx_d = flit_count_q;
        end
      end
    end

    if (exp_ovf || act_ovf) begin
      fifo_overflow_d = 1'b1;
      data_error_d    = 1'b1;
    end

    unique case (state_q)
      RUN: if (wr_rd_done) state_d = DRAIN;
      DRAIN: begin
        if (exp_empty && act_empty && !cmp_vld_q) begin
          state_d     = DONE;
          test_done_d = data_error_d ? TD_FAIL : TD_PASS;
        end else if (stalled) begin
          if (stall_cnt_q == SW'(TIMEOUT - 1)) begin
            timeout_d    = 1'b1;
            data_error_d = 1'b1;
            state_d      = DONE;
            test_done_d  = TD_FAIL;
          end else begin
            stall_cnt_d = stall_cnt_q + SW'(1);
          end
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d         = RUN;
      cmp_vld_d       = 1'b0;
      first_seen_d    = 1'b0;
      data_error_d    = 1'b0;
      test_done_d     = TD_RUN;
      err_count_d     = '0;
      flit_count_d    = '0;
      first_err_idx_d = '1;
      fifo_overflow_d = 1'b0;
      timeout_d       = 1'b0;
      stall_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= RUN;
      cmp_vld_q       <= 1'b0;
      first_seen_q    <= 1'b0;
      data_error_q    <= 1'b0;
      test_done_q     <= TD_RUN;
      err_count_q     <= '0;
      flit_count_q    <= '0;
      first_err_idx_q <= '1;
      fifo_overflow_q <= 1'b0;
      timeout_q       <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      cmp_vld_q       <= cmp_vld_d;
      first_seen_q    <= first_seen_d;
      data_error_q    <= data_error_d;
      test_done_q     <= test_done_d;
      err_count_q     <= err_count_d;
      flit_count_q    <= flit_count_d;
      first_err_idx_q <= first_err_idx_d;
      fifo_overflow_q <= fifo_overflow_d;
      timeout_q       <= timeout_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign data_error    = data_error_q;
  assign test_done     = test_done_q;
  assign err_count     = err_count_q;
  assign flit_count    = flit_count_q;
  assign first_err_idx = first_err_idx_q;
  assign fifo_overflow = fifo_overflow_q;
  assign timeout       = timeout_q;

endmodule
